nes_pad_controller: RTL and testbench

NES_PAD_CONTROLLER -- requirements
Module: nes_pad_controller

---
 rtl/nes_pkg.sv | 38 +++
 rtl/nes_tick_gen.sv | 31 +++
 rtl/nes_pad_controller.sv | 172 +++++++++++++++++
 tb/tb_nes_pad_controller.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/nes_pkg.sv
// Shared types and constants for the NES pad controller.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package nes_pkg;

  // Frame sequencer states
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LATCH  = 3'd1,
    ST_SAMPLE = 3'd2,
    ST_CLK_HI = 3'd3,
    ST_CLK_LO = 3'd4,
    ST_DONE   = 3'd5
  } nes_state_t;

  // Button bit positions in the buttons / release_pulse vectors
  localparam int unsigned BTN_A      = 0;
  localparam int unsigned BTN_B      = 1;
  localparam int unsigned BTN_SELECT = 2;
  localparam int unsigned BTN_START  = 3;
  localparam int unsigned BTN_UP     = 4;
  localparam int unsigned BTN_DOWN   = 5;
  localparam int unsigned BTN_LEFT   = 6;
  localparam int unsigned BTN_RIGHT  = 7;

  // Protocol shape: latch strobe length in ticks, bits per frame
  localparam int unsigned LATCH_TICKS = 2;
  localparam int unsigned NUM_BITS    = 8;

  // Buttons that were held in the previous frame and are no longer held
  function automatic logic [NUM_BITS-1:0] release_mask(
    input logic [NUM_BITS-1:0] old_btn,
    input logic [NUM_BITS-1:0] new_btn
  );
    return old_btn & ~new_btn;
  endfunction

endpackage

// File: rtl/nes_tick_gen.sv
// Protocol tick generator: one-clk strobe every CLK_DIV clk cycles.
// Latency: tick is combinational from the free-running divider count.
// Backpressure: none; the divider never stalls.
module nes_tick_gen
  import nes_pkg::*;
#(
  parameter int unsigned CLK_DIV = 4
) (
  input  logic clk,
  input  logic reset_n,
  output logic tick
);

  localparam logic [15:0] TICK_LAST = 16'(CLK_DIV - 1);

  logic [15:0] div_cnt;

  assign tick = (div_cnt == TICK_LAST);

  // Free-running divider 0..CLK_DIV-1, wrapping on the tick cycle
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      div_cnt <= '0;
    end else if (tick) begin
      div_cnt <= '0;
    end else begin
      div_cnt <= div_cnt + 16'd1;
    end
  end

endmodule

// File: rtl/nes_pad_controller.sv
// NES pad poller: latches and shifts the pad, publishes debounced button state once per frame.
// Latency: 24 ticks from latch rise to frame_valid, frames POLL_TICKS idle ticks apart.
// Backpressure: none; enable only gates the start of the next frame, never aborts one.
// Build option: define NES_RELEASE_PULSE_EN to generate release_pulse, otherwise it is tied low.
module nes_pad_controller
  import nes_pkg::*;
#(
  parameter int unsigned CLK_DIV    = 4,
  parameter int unsigned POLL_TICKS = 16
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       enable,
  input  logic       nes_data,
  output logic       nes_latch,
  output logic       nes_clk,
  output logic [7:0] buttons,
  output logic       frame_valid,
  output logic [7:0] release_pulse
);

  localparam logic [15:0] POLL_LAST  = 16'(POLL_TICKS - 1);
  localparam logic [1:0]  LATCH_LAST = 2'(LATCH_TICKS - 1);
  localparam logic [2:0]  IDX_LAST   = 3'(NUM_BITS - 1);

  logic             tick;
  nes_state_t       state;
  logic [15:0]      poll_cnt;
  logic [1:0]       lat_cnt;
  logic [2:0]       bit_idx;
  logic [7:0]       shift_q;
  logic [1:0]       data_sync;
  logic             sample_bit;
  logic             frame_done;
  logic [7:0]       frame_word;

  nes_tick_gen #(
    .CLK_DIV (CLK_DIV)
  ) u_tick_gen (
    .clk     (clk),
    .reset_n (reset_n),
    .tick    (tick)
  );

  // Two-flop synchronizer; idles high so a reset reads as "not pressed"
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      data_sync <= 2'b11;
    end else begin
      data_sync <= {data_sync[0], nes_data};
    end
  end

  // Pad data is active-low; internal shift register is active-high
  assign sample_bit = ~data_sync[1];

  // Final sample of a frame: the last bit is being captured on this tick
  assign frame_done = (state == ST_SAMPLE) && tick && (bit_idx == IDX_LAST);

  // Complete frame including the bit captured this cycle, so buttons never sees a partial word
  always_comb begin
    frame_word          = shift_q;
    frame_word[bit_idx] = sample_bit;
  end

  // Frame sequencer with registered pad strobes; only DONE advances without a tick
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= ST_IDLE;
      poll_cnt    <= '0;
      lat_cnt     <= '0;
      bit_idx     <= '0;
      shift_q     <= '0;
      buttons     <= '0;
      frame_valid <= 1'b0;
      nes_latch   <= 1'b0;
      nes_clk     <= 1'b0;
    end else begin
      frame_valid <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (tick) begin
            if (poll_cnt == POLL_LAST) begin
              // Counter parks here while enable is low; start on the first enabled tick
              if (enable) begin
                state     <= ST_LATCH;
                poll_cnt  <= '0;
                lat_cnt   <= '0;
                bit_idx   <= '0;
                nes_latch <= 1'b1;
              end
            end else begin
              poll_cnt <= poll_cnt + 16'd1;
            end
          end
        end

        ST_LATCH: begin
          if (tick) begin
            if (lat_cnt == LATCH_LAST) begin
              state     <= ST_SAMPLE;
              nes_latch <= 1'b0;
              bit_idx   <= '0;
            end else begin
              lat_cnt <= lat_cnt + 2'd1;
            end
          end
        end

        ST_SAMPLE: begin
          if (tick) begin
            shift_q[bit_idx] <= sample_bit;
            if (frame_done) begin
              // Publish on entry to DONE so frame_valid and the new word share the DONE clk
              state       <= ST_DONE;
              buttons     <= frame_word;
              frame_valid <= 1'b1;
            end else begin
              state   <= ST_CLK_HI;
              nes_clk <= 1'b1;
            end
          end
        end

        ST_CLK_HI: begin
          if (tick) begin
            state   <= ST_CLK_LO;
            nes_clk <= 1'b0;
            bit_idx <= bit_idx + 3'd1;
          end
        end

        ST_CLK_LO: begin
          if (tick) begin
            state <= ST_SAMPLE;
          end
        end

        ST_DONE: begin
          state    <= ST_IDLE;
          poll_cnt <= '0;
        end

        default: begin
          state     <= ST_IDLE;
          nes_latch <= 1'b0;
          nes_clk   <= 1'b0;
        end
      endcase
    end
  end

`ifdef NES_RELEASE_PULSE_EN
  logic [7:0] release_q;

  // One-clk release strobe aligned with frame_valid, compares outgoing and incoming words
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      release_q <= '0;
    end else if (frame_done) begin
      release_q <= release_mask(buttons, frame_word);
    end else begin
      release_q <= '0;
    end
  end

  assign release_pulse = release_q;
`else
  assign release_pulse = 8'h00;
`endif

endmodule

// File: tb/tb_nes_pad_controller.sv
// Scoreboard bench for nes_pad_controller with a behavioural pad model.
// Latency: expects latch rise + 96 clk to frame_valid at CLK_DIV=4, POLL_TICKS=16.
// Backpressure: exercises enable gating and mid-frame reset.
module tb_nes_pad_controller;

  logic       clk;
  logic       reset_n;
  logic       enable;
  logic       nes_data;
  logic       nes_latch;
  logic       nes_clk;
  logic [7:0] buttons;
  logic       frame_valid;
  logic [7:0] release_pulse;

  nes_pad_controller #(
    .CLK_DIV    (4),
    .POLL_TICKS (16)
  ) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .enable        (enable),
    .nes_data      (nes_data),
    .nes_latch     (nes_latch),
    .nes_clk       (nes_clk),
    .buttons       (buttons),
    .frame_valid   (frame_valid),
    .release_pulse (release_pulse)
  );

  int n_chk  = 0;
  int n_fail = 0;
  int cyc    = 0;

  logic [7:0] pad_state = 8'h00;
  logic [7:0] pad_sr    = 8'h00;
  logic [7:0] exp_q[$];
  logic [7:0] model_btn = 8'h00;
  int         rel_cyc   = 0;
  int         en_expect = 0;
  bit         en_pending = 0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  // Pad: parallel load on latch rise, shift toward bit 0 on each nes_clk rise
  assign nes_data = ~pad_sr[0];
  initial begin
    forever begin
      @(posedge nes_latch or posedge nes_clk);
      if (nes_latch) pad_sr = pad_state;
      else           pad_sr = {1'b0, pad_sr[7:1]};
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  task automatic wait_frame(input int budget);
    bit seen = 0;
    for (int i = 0; i < budget && !seen; i++) begin
      @(negedge clk);
      if (frame_valid) seen = 1;
    end
    chk("frame_timeout", seen, 1);
  endtask

  task automatic wait_latch(input int budget);
    bit seen = 0;
    for (int i = 0; i < budget && !seen; i++) begin
      @(negedge clk);
      if (nes_latch) seen = 1;
    end
    chk("latch_timeout", seen, 1);
  endtask

  // Monitor: protocol timing checks and scoreboard pops on frame_valid
  initial begin
    bit         lat_prev = 0, clk_prev = 0, fv_prev = 0, fv_chain = 0, first_after_rst = 1;
    int         lat_rise = 0, clk_rise = 0, last_fv = 0, pulses = 0;
    logic [7:0] exp_b, exp_r;
    forever begin
      @(negedge clk);
      if (!reset_n) begin
        exp_q.delete();
        model_btn = 8'h00;
        fv_chain = 0; lat_prev = 0; clk_prev = 0; fv_prev = 0;
        first_after_rst = 1; pulses = 0;
      end else begin
        if (nes_latch && !lat_prev) begin
          lat_rise = cyc;
          pulses = 0;
          exp_q.push_back(pad_state);
          if (first_after_rst) begin
            chk("reset_to_latch", cyc - rel_cyc, 64);
            first_after_rst = 0;
          end
          chk("latch_while_disabled", enable, 1);
          if (en_pending) begin
            chk("enable_to_latch", cyc, en_expect);
            en_pending = 0;
          end
        end
        if (!nes_latch && lat_prev) chk("latch_width", cyc - lat_rise, 8);
        if (nes_clk && !clk_prev) begin
          clk_rise = cyc;
          pulses++;
        end
        if (!nes_clk && clk_prev) chk("clk_width", cyc - clk_rise, 4);
        if (!enable) fv_chain = 0;
        if (frame_valid) begin
          chk("fv_single", fv_prev, 0);
          chk("latch_to_valid", cyc - lat_rise, 96);
          chk("clk_pulses", pulses, 7);
          if (fv_chain) chk("valid_spacing", cyc - last_fv, 160);
          if (exp_q.size() == 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL sb_underflow: frame_valid with no expected frame at cycle %0d", cyc);
          end else begin
            exp_b = exp_q.pop_front();
`ifdef NES_RELEASE_PULSE_EN
            exp_r = model_btn & ~exp_b;
`else
            exp_r = 8'h00;
`endif
            chk("buttons", buttons, exp_b);
            chk("release_pulse", release_pulse, exp_r);
            model_btn = exp_b;
          end
          last_fv = cyc;
          fv_chain = 1;
        end else begin
          chk("release_idle", release_pulse, 0);
          chk("buttons_hold", buttons, model_btn);
        end
        lat_prev = nes_latch;
        clk_prev = nes_clk;
        fv_prev  = frame_valid;
      end
    end
  end

  // Stimulus
  initial begin
    logic [7:0] fixed_pads[3];
    bit         prev_c;
    int         rises;
    int         d;
    fixed_pads[0] = 8'hFF;
    fixed_pads[1] = 8'h00;
    fixed_pads[2] = 8'h80;

    reset_n   = 1'b0;
    enable    = 1'b1;
    pad_state = 8'h09;
    repeat (3) @(negedge clk);
    chk("rst_buttons", buttons, 8'h00);
    chk("rst_frame_valid", frame_valid, 0);
    chk("rst_latch", nes_latch, 0);
    chk("rst_nes_clk", nes_clk, 0);
    chk("rst_release", release_pulse, 8'h00);
    reset_n = 1'b1;
    rel_cyc = cyc;

    // A+Start, then all pressed, all released, Right only
    wait_frame(400);
    for (int i = 0; i < 3; i++) begin
      pad_state = fixed_pads[i];
      wait_frame(400);
    end

    // Random pad words
    for (int i = 0; i < 6; i++) begin
      pad_state = 8'($urandom_range(0, 255));
      wait_frame(400);
    end

    // Drop enable in tick 10 of a frame; frame must still complete
    pad_state = 8'($urandom_range(0, 255));
    wait_latch(200);
    repeat (40) @(negedge clk);
    enable = 1'b0;
    wait_frame(400);
    repeat (200) @(negedge clk);
    pad_state = 8'($urandom_range(0, 255));
    enable = 1'b1;
    d = cyc + 1 - rel_cyc;
    en_expect = rel_cyc + 4 * ((d + 3) / 4);
    en_pending = 1;
    wait_frame(400);

    // Reset during the CLK_HI of bit 4
    pad_state = 8'h21;
    wait_frame(400);
    chk("buttons_before_reset", buttons, 8'h21);
    pad_state = 8'h5A;
    wait_latch(200);
    prev_c = 0;
    rises = 0;
    for (int i = 0; i < 200 && rises < 5; i++) begin
      @(negedge clk);
      if (nes_clk && !prev_c) rises++;
      prev_c = nes_clk;
    end
    chk("bit4_clk_timeout", rises, 5);
    #1 reset_n = 1'b0;
    #1;
    chk("midrst_nes_clk", nes_clk, 0);
    chk("midrst_buttons", buttons, 8'h00);
    chk("midrst_latch", nes_latch, 0);
    chk("midrst_frame_valid", frame_valid, 0);
    repeat (3) @(negedge clk);
    pad_state = 8'h3C;
    reset_n = 1'b1;
    rel_cyc = cyc;
    wait_frame(400);
    pad_state = 8'hC3;
    wait_frame(400);
    pad_state = 8'h00;
    wait_frame(400);

    @(negedge clk);
    chk("sb_drained", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
